alink_dispatch: RTL

Parametrised successor to the ALINK TX arbiter: takes queued tasks from the TX FIFO, grants them to one of `PHY_NUM` PHY channels, tracks per-channel busy state, and times out channels whose report does not return. It sits between the TX FIFO/`tx_phy` and `rxc` inside `alink`, feeding `reg_busy` and `timer_cnt` to the Wishbone slave. Relative to the previous arbiter it adds:
- generic channel count and timer width;
- round-robin fairness;
- explicit per-channel timeout events;
- report-driven busy release.

---
 rtl/alink_pkg.sv | 19 +
 rtl/alink_rr_pick.sv | 34 +++
 rtl/alink_dispatch.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alink_pkg.sv
// Shared ALINK definitions: dispatcher FSM encodings and default channel/timer sizing.
// Used by alink, alink_dispatch, rxc and alink_slave.
package alink_pkg;

    localparam int PHY_NUM_DEF = 32;
    localparam int TIMER_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alink_rr_pick.sv
// One-hot channel picker: first free channel at or above the pointer, else the
// lowest free channel (wrap-around). A pointer tied to 0 gives fixed priority.
module alink_rr_pick
    import alink_pkg::*;
#(
    parameter int N     = PHY_NUM_DEF,
    parameter int PTR_W = ptr_width(PHY_NUM_DEF)
) (
    input  logic [N-1:0]     i_free,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic             o_vld
);

    // NOTE: every output gets a default before the loops so no latch is inferred.
    always_comb begin
        o_grant = '0;
        o_vld   = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!o_vld && i_free[j] && (j >= int'(i_ptr))) begin
                o_grant[j] = 1'b1;
                o_vld      = 1'b1;
            end
        end
        // Wrap-around pass: only reached when nothing at or above the pointer is free.
        for (int j = 0; j < N; j++) begin
            if (!o_vld && i_free[j]) begin
                o_grant[j] = 1'b1;
                o_vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alink_dispatch.sv
// ALINK TX dispatcher: grants queued tasks to PHY channels, tracks busy state and
// per-channel timeouts. Define ALINK_DISPATCH_RR_EN for round-robin grant, else fixed priority.
module alink_dispatch
    import alink_pkg::*;
#(
    parameter int PHY_NUM = PHY_NUM_DEF,
    parameter int TIMER_W = TIMER_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reg_flush,
    input  logic [PHY_NUM-1:0]         reg_mask,
    input  logic [TIMER_W-1:0]         reg_tout,
    input  logic                       tx_task_vld,
    output logic                       tx_phy_start,
    output logic [PHY_NUM-1:0]         tx_phy_sel,
    input  logic                       tx_phy_done,
    input  logic [PHY_NUM-1:0]         rx_done,
    output logic [PHY_NUM-1:0]         reg_busy,
    output logic [PHY_NUM-1:0]         tout_evt,
    output logic [TIMER_W*PHY_NUM-1:0] timer_cnt,
    output logic [1:0]                 cur_state
);

    localparam int PTR_W = ptr_width(PHY_NUM);

    state_t                          r_state;
    state_t                          w_next;
    logic                            r_start;
    logic [PHY_NUM-1:0]              r_sel;
    logic [PHY_NUM-1:0]              r_busy;
    logic [PHY_NUM-1:0]              r_tout_evt;
    logic [PHY_NUM-1:0][TIMER_W-1:0] r_timer;

    logic [PHY_NUM-1:0]              w_free;
    logic [PHY_NUM-1:0]              w_grant;
    logic                            w_grant_vld;
    logic [PTR_W-1:0]                w_ptr;
    logic                            w_take;
    logic                            w_complete;

    assign w_free     = reg_mask & ~r_busy;
    assign w_take     = (r_state == ST_IDLE) && tx_task_vld && w_grant_vld && !reg_flush;
    assign w_complete = (r_state == ST_WAIT) && tx_phy_done && !reg_flush;

    alink_rr_pick #(
        .N     (PHY_NUM),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_free  (w_free),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_vld   (w_grant_vld)
    );

`ifdef ALINK_DISPATCH_RR_EN
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;

    // Pointer moves to the channel just after the one that completed.
    always_comb begin
        w_ptr_nxt = '0;
        for (int i = 0; i < PHY_NUM; i++) begin
            if (r_sel[i]) begin
                w_ptr_nxt = (i == PHY_NUM - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (reg_flush) begin
            r_ptr <= '0;
        end else if (w_complete) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (tx_task_vld && w_grant_vld) w_next = ST_START;
            ST_START: w_next = ST_WAIT;
            ST_WAIT:  if (tx_phy_done) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (reg_flush) begin
            w_next = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
            r_sel   <= '0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == ST_START);
            if (reg_flush) begin
                r_sel <= '0;
            end else if (w_take) begin
                r_sel <= w_grant;
            end else if (w_complete) begin
                r_sel <= '0;
            end
        end
    end

    // NOTE: the timer array is reset explicitly; it drives outputs and must read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_timer    <= '0;
            r_tout_evt <= '0;
        end else begin
            r_tout_evt <= '0;
            if (reg_flush) begin
                r_busy  <= '0;
                r_timer <= '0;
            end else begin
                for (int i = 0; i < PHY_NUM; i++) begin
                    if (r_busy[i]) begin
                        // A report on the expiry cycle wins over the timeout.
                        if (rx_done[i]) begin
                            r_busy[i]  <= 1'b0;
                            r_timer[i] <= '0;
                        end else if (r_timer[i] == TIMER_W'(1)) begin
                            r_busy[i]     <= 1'b0;
                            r_timer[i]    <= '0;
                            r_tout_evt[i] <= 1'b1;
                        end else if (r_timer[i] > TIMER_W'(1)) begin
                            r_timer[i] <= r_timer[i] - TIMER_W'(1);
                        end
                    end else if (w_complete && r_sel[i]) begin
                        r_busy[i]  <= 1'b1;
                        r_timer[i] <= reg_tout;
                    end
                end
            end
        end
    end

    assign tx_phy_start = r_start;
    assign tx_phy_sel   = r_sel;
    assign reg_busy     = r_busy;
    assign tout_evt     = r_tout_evt;
    assign timer_cnt    = r_timer;
    assign cur_state    = r_state;

endmodule
